ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-master, one-slave arbiter that shares the single-ported SPRAM bus between master 0 (CPU load/store/fetch) and master 1 (DMA/peripheral engine). It sits between the masters and the `ram` block. It forwards one access at a time and returns the slave's `ready` pulse to the owning master only. Grant is registered, and a mandatory idle cycle between accesses lets the slave's toggling `ready` phase clear.

## Interface
Parameters:
- ROUND_ROBIN, default 1: 1 = alternate priority after each completed access; 0 = fixed priority, master 0 always wins.

Ports (`mX` = `m0`/`m1`; both master ports are identical):
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- mX_address_in  input  32  byte address.
- mX_sel_in  input  1  request. Held, with address/mask/data stable, until the matching `mX_ready_out` pulse.
- mX_write_mask_in  input  4  byte write enables; 0 = read.
- mX_write_value_in  input  32  write data.
- mX_read_value_out  output  32  read data. Valid when `mX_ready_out`=1, otherwise 0.
- mX_ready_out  output  1  one-cycle completion pulse.
- s_address_out  output  32  to `ram.address_in`.
- s_sel_out  output  1  to `ram.sel_in`.
- s_write_mask_out  output  4  to `ram.write_mask_in`.
- s_write_value_out  output  32  to `ram.write_value_in`.
- s_read_value_in  input  32  from `ram.read_value_out`.
- s_ready_in  input  1  from `ram.ready_out`.

## Operation
- State register `state` ∈ {ARB_IDLE, ARB_BUSY}, plus `owner` (1 bit) and `last` (1 bit, last completed owner).
- ARB_IDLE:
  - All `s_*` outputs are 0.
  - If any `mX_sel_in`=1, pick the winner and go to ARB_BUSY with `owner` = winner on the next edge.
  - Winner selection:
    - Only one requester: that master wins.
    - Both request and ROUND_ROBIN=1: the master ≠ `last` wins.
    - Both request and ROUND_ROBIN=0: m0 wins.
- ARB_BUSY:
  - `s_address_out`, `s_write_mask_out` and `s_write_value_out` equal the owner's inputs, combinationally muxed.
  - `s_sel_out` = owner's `sel_in`.
  - When `s_ready_in`=1: `owner_ready_out`=1 and `owner_read_value_out`=`s_read_value_in` in the same cycle. Next state is ARB_IDLE and `last` <= `owner`.
  - Owner drops `sel_in` before ready (abort): next state is ARB_IDLE, no ready is forwarded, and `last` is unchanged. A write may already have been committed.
- Non-owner master: `ready_out`=0 and `read_value_out`=0 at all times. Its request waits, with no loss and no timeout.
- `s_ready_in` seen in ARB_IDLE is ignored and never forwarded.
- Reset values: state=ARB_IDLE, owner=0, last=1 (so m0 wins the first tie). All outputs are 0 during and after reset until a grant.

## Timing
- Request at cycle 0 (IDLE) -> grant edge -> cycle 1 s_sel_out=1 -> slave ready at cycle 2 -> owner ready pulse at cycle 2 -> cycle 3 IDLE with s_sel_out=0.
- Latency from request to ready is 3 cycles with the 2-cycle `ram`. Peak throughput is one access per 3 cycles.
- The IDLE gap cycle is mandatory: it deasserts `s_sel_out`, which resets the slave's ready phase before the next access.
- Simultaneous events:
  - Ready at the same edge a new request arrives from either master: the request is evaluated in the following IDLE cycle, never chained directly.
  - Owner re-asserts a new request right after its ready: it competes normally in IDLE. With ROUND_ROBIN=1 and the other master waiting, the other master wins.
- Reset asserted mid-ARB_BUSY: next edge forces IDLE. `s_sel_out` and all ready outputs are 0 from the first reset cycle, because outputs are gated by `!reset`.
- Starvation bound with ROUND_ROBIN=1: a waiting master is granted within 6 cycles of request.

## Structure
- Package `ram_arbiter_pkg`: `arb_state_t` enum {ARB_IDLE, ARB_BUSY}, localparams for master ids M0=0 and M1=1, and a `bus_req_t` struct {address[31:0], sel, write_mask[3:0], write_value[31:0]}.
- One natural sub-module: `arb_pick`, the combinational winner select (req[1:0], last, ROUND_ROBIN -> winner). It is reused when the arbiter is widened to more masters.

## Test plan
- Single read: m0 reads 0x0000_0100, slave returns 0xDEAD_BEEF at cycle 2 -> m0_ready_out=1 at cycle 2 with 0xDEAD_BEEF, m1 outputs 0, s_sel_out=0 at cycle 3.
- Tie, ROUND_ROBIN=1: both request continuously -> grant order m0, m1, m0, m1, one ready every 3 cycles.
- Tie, ROUND_ROBIN=0: both request continuously -> m0 always wins and m1 is never granted. Drop m0 -> m1 is granted on the next IDLE.
- Write forwarding: m1 writes mask 4'b0100 with value 0x00AA_0000 to 0x20 -> s_write_mask_out=4'b0100 and s_write_value_out=0x00AA_0000 in BUSY only. A subsequent m0 read of 0x20 returns byte 2 = 0xAA.
- Abort: m0 drops sel at cycle 1 -> no m0_ready_out, IDLE at cycle 2, `last` unchanged. A pending m1 request is granted next.
- Reset mid-BUSY: assert reset at cycle 1 -> s_sel_out=0 and all ready outputs 0 immediately. After release, a tie is won by m0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-master SPRAM arbiter.
package ram_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic M0          = 1'b0;
    localparam logic M1          = 1'b1;
    localparam int   NUM_MASTERS = 2;

    typedef struct packed {
        logic [31:0] address;
        logic        sel;
        logic [3:0]  write_mask;
        logic [31:0] write_value;
    } bus_req_t;

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational winner select between two requesters.
module arb_pick
    import ram_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = M0;
        if (req == 2'b11)
            winner = ROUND_ROBIN ? ~last : M0;
        else if (req[M1])
            winner = M1;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of the single-ported SPRAM; one access at a time
// with a forced idle cycle between grants so the slave's ready phase clears.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address_in,
    input  logic        m0_sel_in,
    input  logic [3:0]  m0_write_mask_in,
    input  logic [31:0] m0_write_value_in,
    output logic [31:0] m0_read_value_out,
    output logic        m0_ready_out,
    input  logic [31:0] m1_address_in,
    input  logic        m1_sel_in,
    input  logic [3:0]  m1_write_mask_in,
    input  logic [31:0] m1_write_value_in,
    output logic [31:0] m1_read_value_out,
    output logic        m1_ready_out,
    output logic [31:0] s_address_out,
    output logic        s_sel_out,
    output logic [3:0]  s_write_mask_out,
    output logic [31:0] s_write_value_out,
    input  logic [31:0] s_read_value_in,
    input  logic        s_ready_in
);

    bus_req_t [NUM_MASTERS-1:0]        mreq;
    logic     [NUM_MASTERS-1:0]        req;
    bus_req_t                          s_req;
    logic     [NUM_MASTERS-1:0]        rdy;
    logic     [NUM_MASTERS-1:0][31:0]  rdata;

    arb_state_t state, state_nxt;
    logic       owner, owner_nxt;
    logic       last, last_nxt;
    logic       winner;

    assign mreq[M0] = {m0_address_in, m0_sel_in, m0_write_mask_in, m0_write_value_in};
    assign mreq[M1] = {m1_address_in, m1_sel_in, m1_write_mask_in, m1_write_value_in};
    assign req      = {m1_sel_in, m0_sel_in};

    arb_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .req    (req),
        .last   (last),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= M0;
            last  <= M1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            ARB_IDLE: begin
                if (|req) begin
                    state_nxt = ARB_BUSY;
                    owner_nxt = winner;
                end
            end
            ARB_BUSY: begin
                if (s_ready_in) begin
                    state_nxt = ARB_IDLE;
                    last_nxt  = owner;
                end else if (!mreq[owner].sel) begin
                    // aborted access: priority history is left untouched
                    state_nxt = ARB_IDLE;
                end
            end
        endcase
    end

    // Outputs are gated by reset so the slave bus drops on the first reset cycle.
    always_comb begin
        s_req = '0;
        rdy   = '0;
        rdata = '0;
        if (!reset && state == ARB_BUSY) begin
            s_req = mreq[owner];
            if (s_ready_in) begin
                rdy[owner]   = 1'b1;
                rdata[owner] = s_read_value_in;
            end
        end
    end

    assign s_address_out     = s_req.address;
    assign s_sel_out         = s_req.sel;
    assign s_write_mask_out  = s_req.write_mask;
    assign s_write_value_out = s_req.write_value;

    assign m0_ready_out      = rdy[M0];
    assign m1_ready_out      = rdy[M1];
    assign m0_read_value_out = rdata[M0];
    assign m1_read_value_out = rdata[M1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin and fixed-priority instances share the
// master stimulus; each drives its own two-cycle SPRAM model.
module tb_ram_arbiter;

    logic        clk, reset;
    logic [31:0] m0_address_in, m1_address_in;
    logic        m0_sel_in, m1_sel_in;
    logic [3:0]  m0_write_mask_in, m1_write_mask_in;
    logic [31:0] m0_write_value_in, m1_write_value_in;

    logic [31:0] a_m0_read_value_out, a_m1_read_value_out, b_m0_read_value_out, b_m1_read_value_out;
    logic        a_m0_ready_out, a_m1_ready_out, b_m0_ready_out, b_m1_ready_out;
    logic [31:0] a_s_address_out, a_s_write_value_out, a_s_read_value_in;
    logic [31:0] b_s_address_out, b_s_write_value_out, b_s_read_value_in;
    logic        a_s_sel_out, a_s_ready_in, b_s_sel_out, b_s_ready_in;
    logic [3:0]  a_s_write_mask_out, b_s_write_mask_out;

    logic [31:0] mem_a [0:127];
    logic [31:0] mem_b [0:127];
    logic [31:0] ref_mem [0:127];
    logic        rdy_a, rdy_b;

    typedef struct {
        bit          m;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int tests = 0;
    int fails = 0;
    logic [1:0]  got_v, exp_v;
    logic [31:0] a_rd, b_rd;
    bit          seen;

    assign a_rd = a_m1_ready_out ? a_m1_read_value_out : a_m0_read_value_out;
    assign b_rd = b_m1_ready_out ? b_m1_read_value_out : b_m0_read_value_out;

    ram_arbiter dut_a (
        .clk(clk), .reset(reset),
        .m0_address_in(m0_address_in), .m0_sel_in(m0_sel_in),
        .m0_write_mask_in(m0_write_mask_in), .m0_write_value_in(m0_write_value_in),
        .m0_read_value_out(a_m0_read_value_out), .m0_ready_out(a_m0_ready_out),
        .m1_address_in(m1_address_in), .m1_sel_in(m1_sel_in),
        .m1_write_mask_in(m1_write_mask_in), .m1_write_value_in(m1_write_value_in),
        .m1_read_value_out(a_m1_read_value_out), .m1_ready_out(a_m1_ready_out),
        .s_address_out(a_s_address_out), .s_sel_out(a_s_sel_out),
        .s_write_mask_out(a_s_write_mask_out), .s_write_value_out(a_s_write_value_out),
        .s_read_value_in(a_s_read_value_in), .s_ready_in(a_s_ready_in)
    );

    ram_arbiter #(.ROUND_ROBIN(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .m0_address_in(m0_address_in), .m0_sel_in(m0_sel_in),
        .m0_write_mask_in(m0_write_mask_in), .m0_write_value_in(m0_write_value_in),
        .m0_read_value_out(b_m0_read_value_out), .m0_ready_out(b_m0_ready_out),
        .m1_address_in(m1_address_in), .m1_sel_in(m1_sel_in),
        .m1_write_mask_in(m1_write_mask_in), .m1_write_value_in(m1_write_value_in),
        .m1_read_value_out(b_m1_read_value_out), .m1_ready_out(b_m1_ready_out),
        .s_address_out(b_s_address_out), .s_sel_out(b_s_sel_out),
        .s_write_mask_out(b_s_write_mask_out), .s_write_value_out(b_s_write_value_out),
        .s_read_value_in(b_s_read_value_in), .s_ready_in(b_s_ready_in)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 'h40) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i * 4);
    endfunction

    // Slave: ready in the second cycle of sel, phase cleared when sel drops.
    always @(posedge clk) begin
        if (reset) begin
            rdy_a <= 1'b0;
            rdy_b <= 1'b0;
            for (int i = 0; i < 128; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
        end else begin
            rdy_a <= a_s_sel_out && !rdy_a;
            rdy_b <= b_s_sel_out && !rdy_b;
            for (int k = 0; k < 4; k++) begin
                if (a_s_sel_out && rdy_a && a_s_write_mask_out[k])
                    mem_a[a_s_address_out[8:2]][k*8 +: 8] <= a_s_write_value_out[k*8 +: 8];
                if (b_s_sel_out && rdy_b && b_s_write_mask_out[k])
                    mem_b[b_s_address_out[8:2]][k*8 +: 8] <= b_s_write_value_out[k*8 +: 8];
            end
        end
    end

    assign a_s_ready_in      = rdy_a;
    assign b_s_ready_in      = rdy_b;
    assign a_s_read_value_in = mem_a[a_s_address_out[8:2]];
    assign b_s_read_value_in = mem_b[b_s_address_out[8:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_m(input bit m, input bit sel, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] wv);
        if (m) begin
            m1_sel_in = sel; m1_address_in = addr; m1_write_mask_in = mask; m1_write_value_in = wv;
        end else begin
            m0_sel_in = sel; m0_address_in = addr; m0_write_mask_in = mask; m0_write_value_in = wv;
        end
    endtask

    task automatic push(input bit m, input logic [31:0] d);
        exp_t x;
        x.m = m;
        x.d = d;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_m(0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0);
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_m(0, 1, 32'h100, 4'h0, 0);
        set_m(1, 1, 32'h104, 4'hF, 32'h1234_5678);
        cyc();
        cyc();
        smp();
        tests++;
        if ({a_s_sel_out, a_s_address_out, a_s_write_mask_out, a_s_write_value_out, a_m0_ready_out,
             a_m1_ready_out, a_m0_read_value_out, a_m1_read_value_out, b_s_sel_out, b_s_address_out} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: s_sel=%b addr=%h mask=%h rdy=%b%b, required all 0",
                     a_s_sel_out, a_s_address_out, a_s_write_mask_out, a_m1_ready_out, a_m0_ready_out);
        end
        cyc();
        reset = 1'b0;
        set_m(0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0);
        smp();
        tests++;
        if ({a_s_sel_out, a_s_address_out, a_m0_ready_out, a_m1_ready_out} !== '0) begin
            fails++;
            $display("FAIL reset_release: s_sel=%b addr=%h, required 0", a_s_sel_out, a_s_address_out);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        cyc();
        set_m(0, 1, 32'h0000_0100, 4'h0, 0);
        push(0, ref_mem['h40]);
        smp();
        tests++;
        if (a_s_sel_out !== 1'b0) begin
            fails++; $display("FAIL read_c0_sel: got %b, required 0", a_s_sel_out);
        end
        cyc();
        smp();
        tests++;
        if (a_s_sel_out !== 1'b1 || a_s_address_out !== 32'h100 || a_m0_ready_out !== 1'b0) begin
            fails++;
            $display("FAIL read_c1_bus: sel=%b addr=%h rdy=%b, required 1 00000100 0",
                     a_s_sel_out, a_s_address_out, a_m0_ready_out);
        end
        cyc();
        smp();
        tests++;
        if (a_m0_ready_out !== 1'b1 || a_m1_ready_out !== 1'b0 || a_m1_read_value_out !== 32'h0) begin
            fails++;
            $display("FAIL read_c2_ready: m0_rdy=%b m1_rdy=%b m1_data=%h, required 1 0 0",
                     a_m0_ready_out, a_m1_ready_out, a_m1_read_value_out);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (a_m0_read_value_out !== e.d) begin
                fails++; $display("FAIL read_data: got %h, required %h", a_m0_read_value_out, e.d);
            end
        end
        cyc();
        set_m(0, 0, 0, 0, 0);
        smp();
        tests++;
        if (a_s_sel_out !== 1'b0 || a_m0_ready_out !== 1'b0 || a_m0_read_value_out !== 32'h0) begin
            fails++;
            $display("FAIL read_c3_idle: sel=%b rdy=%b data=%h, required 0 0 0",
                     a_s_sel_out, a_m0_ready_out, a_m0_read_value_out);
        end
    endtask

    task automatic test_rr_tie();
        do_reset();
        cyc();
        set_m(0, 1, 32'h10, 4'h0, 0);
        set_m(1, 1, 32'h14, 4'h0, 0);
        push(0, ref_mem[4]); push(1, ref_mem[5]); push(0, ref_mem[4]); push(1, ref_mem[5]);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) cyc();
            if (c == 12) begin
                set_m(0, 0, 0, 0, 0);
                set_m(1, 0, 0, 0, 0);
            end
            smp();
            got_v = {a_m1_ready_out, a_m0_ready_out};
            exp_v = (c == 2 || c == 8) ? 2'b01 : (c == 5 || c == 11) ? 2'b10 : 2'b00;
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL rr_ready c%0d: got %b, required %b", c, got_v, exp_v);
            end
            if (got_v != 0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if (a_m1_ready_out !== e.m || a_rd !== e.d) begin
                    fails++;
                    $display("FAIL rr_sb c%0d: got m%0d %h, required m%0d %h", c, a_m1_ready_out, a_rd, e.m, e.d);
                end
            end
        end
    endtask

    task automatic test_fixed_tie();
        do_reset();
        cyc();
        set_m(0, 1, 32'h10, 4'h0, 0);
        set_m(1, 1, 32'h14, 4'h0, 0);
        for (int i = 0; i < 4; i++) push(0, ref_mem[4]);
        push(1, ref_mem[5]);
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) cyc();
            if (c == 12) set_m(0, 0, 0, 0, 0);
            if (c == 15) set_m(1, 0, 0, 0, 0);
            smp();
            got_v = {b_m1_ready_out, b_m0_ready_out};
            exp_v = (c == 2 || c == 5 || c == 8 || c == 11) ? 2'b01 : (c == 14) ? 2'b10 : 2'b00;
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL fixed_ready c%0d: got %b, required %b", c, got_v, exp_v);
            end
            if (c == 13) begin
                tests++;
                if (b_s_address_out !== 32'h14) begin
                    fails++; $display("FAIL fixed_m1_grant: addr %h, required 00000014", b_s_address_out);
                end
            end
            if (got_v != 0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if (b_m1_ready_out !== e.m || b_rd !== e.d) begin
                    fails++;
                    $display("FAIL fixed_sb c%0d: got m%0d %h, required m%0d %h", c, b_m1_ready_out, b_rd, e.m, e.d);
                end
            end
        end
    endtask

    task automatic test_write_fwd();
        do_reset();
        cyc();
        set_m(1, 1, 32'h20, 4'b0100, 32'h00AA_0000);
        push(1, ref_mem[8]);
        ref_mem[8][23:16] = 8'hAA;
        smp();
        tests++;
        if (a_s_write_mask_out !== 4'h0 || a_s_write_value_out !== 32'h0) begin
            fails++;
            $display("FAIL wr_idle_bus: mask=%b val=%h, required 0000 0", a_s_write_mask_out, a_s_write_value_out);
        end
        cyc();
        smp();
        tests++;
        if (a_s_write_mask_out !== 4'b0100 || a_s_write_value_out !== 32'h00AA_0000 || a_s_address_out !== 32'h20) begin
            fails++;
            $display("FAIL wr_busy_bus: mask=%b val=%h addr=%h, required 0100 00aa0000 00000020",
                     a_s_write_mask_out, a_s_write_value_out, a_s_address_out);
        end
        cyc();
        smp();
        tests++;
        if (a_m1_ready_out !== 1'b1 || exp_q.size() == 0) begin
            fails++; $display("FAIL wr_ready: got %b, required 1", a_m1_ready_out);
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (a_m1_read_value_out !== e.d) begin
                fails++; $display("FAIL wr_sb: got %h, required %h", a_m1_read_value_out, e.d);
            end
        end
        cyc();
        set_m(1, 0, 0, 0, 0);
        smp();
        tests++;
        if (a_s_write_mask_out !== 4'h0 || a_s_write_value_out !== 32'h0) begin
            fails++;
            $display("FAIL wr_after_bus: mask=%b val=%h, required 0000 0", a_s_write_mask_out, a_s_write_value_out);
        end
        cyc();
        set_m(0, 1, 32'h20, 4'h0, 0);
        push(0, ref_mem[8]);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            if (k > 0) cyc();
            smp();
            if (a_m0_ready_out) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                tests++;
                if (a_m0_read_value_out !== e.d || a_m0_read_value_out[23:16] !== 8'hAA) begin
                    fails++;
                    $display("FAIL wr_readback: got %h, required %h (byte2 aa)", a_m0_read_value_out, e.d);
                end
            end
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL wr_readback_timeout: no m0 ready in 6 cycles, required one");
        end
        cyc();
        set_m(0, 0, 0, 0, 0);
    endtask

    task automatic test_abort();
        // aborted m0 access must leave last=M1, so the following tie goes to m0
        do_reset();
        cyc();
        set_m(0, 1, 32'h30, 4'h0, 0);
        cyc();
        set_m(0, 0, 0, 0, 0);
        smp();
        tests++;
        if (a_s_sel_out !== 1'b0 || a_m0_ready_out !== 1'b0) begin
            fails++; $display("FAIL abort_c1: sel=%b rdy=%b, required 0 0", a_s_sel_out, a_m0_ready_out);
        end
        cyc();
        set_m(0, 1, 32'h30, 4'h0, 0);
        set_m(1, 1, 32'h34, 4'h0, 0);
        push(0, ref_mem[12]); push(1, ref_mem[13]);
        smp();
        tests++;
        if (a_s_sel_out !== 1'b0 || {a_m1_ready_out, a_m0_ready_out} !== 2'b00) begin
            fails++; $display("FAIL abort_c2_idle: sel=%b, required 0", a_s_sel_out);
        end
        for (int c = 3; c <= 8; c++) begin
            cyc();
            if (c == 5) set_m(0, 0, 0, 0, 0);
            if (c == 8) set_m(1, 0, 0, 0, 0);
            smp();
            if (c == 3) begin
                tests++;
                if (a_s_address_out !== 32'h30) begin
                    fails++; $display("FAIL abort_last_kept: addr %h, required 00000030", a_s_address_out);
                end
            end
            got_v = {a_m1_ready_out, a_m0_ready_out};
            exp_v = (c == 4) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL abort_ready c%0d: got %b, required %b", c, got_v, exp_v);
            end
            if (got_v != 0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if (a_m1_ready_out !== e.m || a_rd !== e.d) begin
                    fails++;
                    $display("FAIL abort_sb c%0d: got m%0d %h, required m%0d %h", c, a_m1_ready_out, a_rd, e.m, e.d);
                end
            end
        end
        // owner m0 aborts while m1 waits: m1 takes the next grant
        cyc();
        set_m(0, 1, 32'h30, 4'h0, 0);
        set_m(1, 1, 32'h34, 4'h0, 0);
        cyc();
        set_m(0, 0, 0, 0, 0);
        push(1, ref_mem[13]);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) cyc();
            if (c == 5) set_m(1, 0, 0, 0, 0);
            smp();
            if (c == 3) begin
                tests++;
                if (a_s_sel_out !== 1'b1 || a_s_address_out !== 32'h34) begin
                    fails++;
                    $display("FAIL abort_pending_grant: sel=%b addr=%h, required 1 00000034", a_s_sel_out, a_s_address_out);
                end
            end
            got_v = {a_m1_ready_out, a_m0_ready_out};
            exp_v = (c == 4) ? 2'b10 : 2'b00;
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL abort2_ready c%0d: got %b, required %b", c, got_v, exp_v);
            end
            if (got_v != 0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if (a_m1_ready_out !== e.m || a_rd !== e.d) begin
                    fails++;
                    $display("FAIL abort2_sb c%0d: got m%0d %h, required m%0d %h", c, a_m1_ready_out, a_rd, e.m, e.d);
                end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        cyc();
        set_m(0, 1, 32'h40, 4'h0, 0);
        cyc();
        reset = 1'b1;
        set_m(1, 1, 32'h44, 4'h0, 0);
        for (int c = 1; c <= 2; c++) begin
            if (c > 1) cyc();
            smp();
            tests++;
            if ({a_s_sel_out, a_m0_ready_out, a_m1_ready_out, b_s_sel_out, b_m0_ready_out, b_m1_ready_out} !== 6'b0) begin
                fails++;
                $display("FAIL rst_busy c%0d: sel=%b rdy=%b%b, required 0 00", c, a_s_sel_out, a_m1_ready_out, a_m0_ready_out);
            end
        end
        cyc();
        reset = 1'b0;
        push(0, ref_mem[16]); push(1, ref_mem[17]);
        for (int c = 3; c <= 9; c++) begin
            if (c > 3) cyc();
            if (c == 6) set_m(0, 0, 0, 0, 0);
            if (c == 9) set_m(1, 0, 0, 0, 0);
            smp();
            if (c == 4) begin
                tests++;
                if (a_s_address_out !== 32'h40) begin
                    fails++; $display("FAIL rst_tie_m0: addr %h, required 00000040", a_s_address_out);
                end
            end
            got_v = {a_m1_ready_out, a_m0_ready_out};
            exp_v = (c == 5) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL rst_ready c%0d: got %b, required %b", c, got_v, exp_v);
            end
            if (got_v != 0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if (a_m1_ready_out !== e.m || a_rd !== e.d) begin
                    fails++;
                    $display("FAIL rst_sb c%0d: got m%0d %h, required m%0d %h", c, a_m1_ready_out, a_rd, e.m, e.d);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_m(0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0);
        test_reset();
        test_single_read();
        test_rr_tie();
        test_fixed_tie();
        test_write_fwd();
        test_abort();
        test_reset_mid_busy();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL sb_leftover: %0d entries pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
